// File: rtl/axi4_lite_sram_bridge_if.sv
// AXI4-Lite bus bundle between an interconnect master and the SRAM bridge slave.
// Latency: none, wires only.
// Backpressure: carries the standard VALID/READY pairs of the five AXI4-Lite channels.
interface axi4_lite_sram_bridge_if #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH     = 32
);
  logic [AXI_ADDR_WIDTH-1:0] AWADDR;
  logic                      AWVALID;
  logic                      AWREADY;
  logic [DATA_WIDTH-1:0]     WDATA;
  logic [DATA_WIDTH/8-1:0]   WSTRB;
  logic                      WVALID;
  logic                      WREADY;
  logic [1:0]                BRESP;
  logic                      BVALID;
  logic                      BREADY;
  logic [AXI_ADDR_WIDTH-1:0] ARADDR;
  logic                      ARVALID;
  logic                      ARREADY;
  logic [DATA_WIDTH-1:0]     RDATA;
  logic [1:0]                RRESP;
  logic                      RVALID;
  logic                      RREADY;

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi4_lite_sram_bridge.sv
// AXI4-Lite slave serialising reads/writes onto a single-port register-file SRAM, with RMW for partial strobes.
// Latency: READY 1 cycle after request; WEN 1 cycle after W handshake (+RD_LATENCY for RMW); RVALID RD_LATENCY+1 after AR handshake.
// Backpressure: one transaction in flight; B/R held until BREADY/RREADY, no READY asserted outside IDLE.
module axi4_lite_sram_bridge #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int NUM_REGS       = 16,
  parameter int RD_LATENCY     = 1
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  axi4_lite_sram_bridge_if.slave    bus,
  output logic [REG_ADDR_WIDTH-1:0] ADDR,
  output logic [DATA_WIDTH-1:0]     W_DATA,
  output logic                      WEN,
  input  logic [DATA_WIDTH-1:0]     R_DATA
);
  localparam int OFF    = $clog2(DATA_WIDTH / 8);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(RD_LATENCY - 1);
  localparam logic [REG_ADDR_WIDTH:0] NUM_REGS_W = (REG_ADDR_WIDTH + 1)'(NUM_REGS);
  localparam logic [STRB_W-1:0] STRB_ALL = '1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, WR_RD, WR_EXEC, WR_RESP, RD_WAIT, RD_RESP} state_t;

  state_t                    state;
  logic                      last_wr;
  logic [REG_ADDR_WIDTH-1:0] cap_idx;
  logic                      cap_err;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [STRB_W-1:0]         wstrb_q;
  logic [CNT_W-1:0]          lat_cnt;

  logic [REG_ADDR_WIDTH-1:0] aw_idx, ar_idx;
  logic                      aw_err, ar_err;
  logic                      wr_pend, rd_pend, grant_wr, grant_rd;
  logic [DATA_WIDTH-1:0]     merged;
  logic                      unused_addr_bits;

  // Address decode and round-robin arbitration between a pending write and a pending read.
  always_comb begin
    aw_idx   = bus.AWADDR[OFF +: REG_ADDR_WIDTH];
    ar_idx   = bus.ARADDR[OFF +: REG_ADDR_WIDTH];
    aw_err   = ({1'b0, aw_idx} >= NUM_REGS_W);
    ar_err   = ({1'b0, ar_idx} >= NUM_REGS_W);
    wr_pend  = bus.AWVALID && bus.WVALID;
    rd_pend  = bus.ARVALID;
    grant_wr = wr_pend && (!rd_pend || !last_wr);
    grant_rd = rd_pend && !grant_wr;
  end

  // Byte merge for read-modify-write: strobed bytes from WDATA, the rest from the SRAM word.
  always_comb begin
    merged = R_DATA;
    for (int b = 0; b < STRB_W; b++) begin
      if (wstrb_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
    end
  end

  // Byte-offset and above-index address bits are don't-care by design.
  assign unused_addr_bits = ^{bus.AWADDR[OFF-1:0], bus.AWADDR[AXI_ADDR_WIDTH-1:OFF+REG_ADDR_WIDTH],
                              bus.ARADDR[OFF-1:0], bus.ARADDR[AXI_ADDR_WIDTH-1:OFF+REG_ADDR_WIDTH]};

  // Transaction FSM; every bus and SRAM output is a register driven from here.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      last_wr     <= 1'b1;
      cap_idx     <= '0;
      cap_err     <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      lat_cnt     <= '0;
      bus.AWREADY <= 1'b0;
      bus.WREADY  <= 1'b0;
      bus.ARREADY <= 1'b0;
      bus.BVALID  <= 1'b0;
      bus.BRESP   <= RESP_OKAY;
      bus.RVALID  <= 1'b0;
      bus.RRESP   <= RESP_OKAY;
      bus.RDATA   <= '0;
      ADDR        <= '0;
      W_DATA      <= '0;
      WEN         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.AWREADY) begin
            // Write handshake cycle: dispatch on the captured decode.
            bus.AWREADY <= 1'b0;
            bus.WREADY  <= 1'b0;
            last_wr     <= 1'b1;
            if (cap_err) begin
              bus.BVALID <= 1'b1;
              bus.BRESP  <= RESP_SLVERR;
              state      <= WR_RESP;
            end else if (wstrb_q == '0) begin
              bus.BVALID <= 1'b1;
              bus.BRESP  <= RESP_OKAY;
              state      <= WR_RESP;
            end else if (wstrb_q == STRB_ALL) begin
              ADDR   <= cap_idx;
              W_DATA <= wdata_q;
              WEN    <= 1'b1;
              state  <= WR_EXEC;
            end else begin
              ADDR    <= cap_idx;
              lat_cnt <= LAT_INIT;
              state   <= WR_RD;
            end
          end else if (bus.ARREADY) begin
            bus.ARREADY <= 1'b0;
            last_wr     <= 1'b0;
            if (cap_err) begin
              bus.RDATA  <= '0;
              bus.RRESP  <= RESP_SLVERR;
              bus.RVALID <= 1'b1;
              state      <= RD_RESP;
            end else begin
              ADDR    <= cap_idx;
              lat_cnt <= LAT_INIT;
              state   <= RD_WAIT;
            end
          end else if (grant_wr) begin
            bus.AWREADY <= 1'b1;
            bus.WREADY  <= 1'b1;
            cap_idx     <= aw_idx;
            cap_err     <= aw_err;
            wdata_q     <= bus.WDATA;
            wstrb_q     <= bus.WSTRB;
          end else if (grant_rd) begin
            bus.ARREADY <= 1'b1;
            cap_idx     <= ar_idx;
            cap_err     <= ar_err;
          end
        end
        WR_RD: begin
          if (lat_cnt == '0) begin
            W_DATA <= merged;
            WEN    <= 1'b1;
            state  <= WR_EXEC;
          end else begin
            lat_cnt <= lat_cnt - CNT_W'(1);
          end
        end
        WR_EXEC: begin
          WEN        <= 1'b0;
          bus.BVALID <= 1'b1;
          bus.BRESP  <= RESP_OKAY;
          state      <= WR_RESP;
        end
        WR_RESP: begin
          if (bus.BREADY) begin
            bus.BVALID <= 1'b0;
            bus.BRESP  <= RESP_OKAY;
            state      <= IDLE;
          end
        end
        RD_WAIT: begin
          if (lat_cnt == '0) begin
            bus.RDATA  <= R_DATA;
            bus.RRESP  <= RESP_OKAY;
            bus.RVALID <= 1'b1;
            state      <= RD_RESP;
          end else begin
            lat_cnt <= lat_cnt - CNT_W'(1);
          end
        end
        RD_RESP: begin
          if (bus.RREADY) begin
            bus.RVALID <= 1'b0;
            bus.RRESP  <= RESP_OKAY;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_lite_sram_bridge.sv
// Self-checking bench for the AXI4-Lite to SRAM bridge with a behavioural register-file SRAM.
// Latency: checks WEN and RVALID timing relative to the address handshakes.
// Backpressure: holds BREADY/RREADY low for several cycles and checks response stability.
module tb_axi4_lite_sram_bridge;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RAW = 4;
  localparam int NR = 12;
  localparam int RL = 1;
  localparam logic [1:0] OK = 2'b00;
  localparam logic [1:0] SE = 2'b10;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  axi4_lite_sram_bridge_if #(.AXI_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  logic [RAW-1:0] ADDR;
  logic [DW-1:0]  W_DATA;
  logic [DW-1:0]  R_DATA;
  logic           WEN;

  axi4_lite_sram_bridge #(
    .AXI_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_ADDR_WIDTH(RAW), .NUM_REGS(NR), .RD_LATENCY(RL)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus), .ADDR(ADDR), .W_DATA(W_DATA), .WEN(WEN), .R_DATA(R_DATA)
  );

  // Register-file SRAM model: combinational read, write on WEN, back-door load port.
  logic [DW-1:0] mem [0:15];
  logic          load_vld = 1'b0;
  logic [3:0]    load_idx = '0;
  logic [DW-1:0] load_dat = '0;
  assign R_DATA = mem[ADDR];
  always @(posedge CLK) begin
    if (load_vld) mem[load_idx] <= load_dat;
    else if (WEN) mem[ADDR] <= W_DATA;
  end

  typedef struct { bit is_wr; logic [1:0] resp; logic [31:0] data; } exp_t;
  typedef struct { logic [3:0] addr; logic [31:0] data; } wexp_t;
  exp_t  sb [$];
  wexp_t wq [$];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int wen_cnt = 0;
  int last_wen_cyc = 0;
  exp_t  mon_e;
  wexp_t mon_w;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic fail_to(input string name);
    n_chk++;
    $display("FAIL %s: got no DUT event, required one within 50 cycles", name);
  endtask

  // Scoreboard monitor: SRAM writes and B/R handshakes popped against expectations.
  always @(negedge CLK) begin
    if (RST_N) begin
      if (WEN) begin
        wen_cnt++;
        last_wen_cyc = cyc;
        if (wq.size() == 0) begin
          n_chk++;
          $display("FAIL wen_unexpected: got WEN addr %0h, required no WEN", ADDR);
        end else begin
          mon_w = wq.pop_front();
          check("wen_addr", 64'(ADDR), 64'(mon_w.addr));
          check("wen_data", 64'(W_DATA), 64'(mon_w.data));
        end
      end
      if (bus.BVALID && bus.BREADY) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL b_unexpected: got B resp %0h, required none", bus.BRESP);
        end else begin
          mon_e = sb.pop_front();
          check("b_order_is_wr", 64'(1), 64'(mon_e.is_wr));
          check("bresp", 64'(bus.BRESP), 64'(mon_e.resp));
        end
      end
      if (bus.RVALID && bus.RREADY) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL r_unexpected: got R data %0h, required none", bus.RDATA);
        end else begin
          mon_e = sb.pop_front();
          check("r_order_is_rd", 64'(0), 64'(mon_e.is_wr));
          check("rresp", 64'(bus.RRESP), 64'(mon_e.resp));
          check("rdata", 64'(bus.RDATA), 64'(mon_e.data));
        end
      end
    end
  end

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          dly;    // write: WEN cycles after AWREADY (0 = no WEN); read: RVALID cycles after ARREADY
    logic [3:0]  waddr;
    logic [31:0] wdata;
    int          bp;
  } vec_t;

  task automatic do_write(input vec_t v);
    int t;
    int aw_cyc;
    int w0;
    int bad;
    sb.push_back('{1'b1, v.resp, 32'h0});
    if (v.dly > 0) wq.push_back('{v.waddr, v.wdata});
    @(posedge CLK); #1;
    bus.AWADDR = v.addr; bus.WDATA = v.data; bus.WSTRB = v.strb;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    t = 0;
    do begin @(negedge CLK); t++; end while (!bus.AWREADY && t < 50);
    if (!bus.AWREADY) begin
      fail_to("aw_handshake");
      bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
      return;
    end
    check("wready_with_awready", 64'(bus.WREADY), 64'(1));
    aw_cyc = cyc;
    w0 = wen_cnt;
    @(posedge CLK); #1;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    t = 0;
    while (!bus.BVALID && t < 50) begin @(negedge CLK); t++; end
    if (!bus.BVALID) begin fail_to("bvalid"); return; end
    bad = 0;
    repeat (v.bp) begin
      @(negedge CLK);
      if (!bus.BVALID || bus.BRESP !== v.resp || bus.AWREADY || bus.WREADY || bus.ARREADY) bad++;
    end
    if (v.bp > 0) check("b_backpressure_unstable", 64'(bad), 64'(0));
    @(posedge CLK); #1 bus.BREADY = 1'b1;
    @(posedge CLK); #1 bus.BREADY = 1'b0;
    check("wen_pulses", 64'(wen_cnt - w0), (v.dly > 0) ? 64'(1) : 64'(0));
    if (v.dly > 0) check("wen_delay", 64'(last_wen_cyc - aw_cyc), 64'(v.dly));
  endtask

  task automatic do_read(input vec_t v);
    int t;
    int ar_cyc;
    int bad;
    sb.push_back('{1'b0, v.resp, v.rdata});
    @(posedge CLK); #1;
    bus.ARADDR = v.addr; bus.ARVALID = 1'b1;
    t = 0;
    do begin @(negedge CLK); t++; end while (!bus.ARREADY && t < 50);
    if (!bus.ARREADY) begin fail_to("ar_handshake"); bus.ARVALID = 1'b0; return; end
    ar_cyc = cyc;
    @(posedge CLK); #1 bus.ARVALID = 1'b0;
    t = 0;
    do begin @(negedge CLK); t++; end while (!bus.RVALID && t < 50);
    if (!bus.RVALID) begin fail_to("rvalid"); return; end
    check("rvalid_latency", 64'(cyc - ar_cyc), 64'(v.dly));
    bad = 0;
    repeat (v.bp) begin
      @(negedge CLK);
      if (!bus.RVALID || bus.RRESP !== v.resp || bus.RDATA !== v.rdata ||
          bus.AWREADY || bus.WREADY || bus.ARREADY) bad++;
    end
    if (v.bp > 0) check("r_backpressure_unstable", 64'(bad), 64'(0));
    @(posedge CLK); #1 bus.RREADY = 1'b1;
    @(posedge CLK); #1 bus.RREADY = 1'b0;
  endtask

  vec_t vecs [12];
  bit   grants [6];

  initial begin
    int t;
    int ng;
    int w0;
    vec_t rv;
    vecs[0]  = '{1'b1, 32'h08,  32'hDEADBEEF, 4'hF, OK, 32'h0,        1, 4'd2,  32'hDEADBEEF, 0};
    vecs[1]  = '{1'b0, 32'h08,  32'h0,        4'h0, OK, 32'hDEADBEEF, 2, 4'd0,  32'h0,        0};
    vecs[2]  = '{1'b1, 32'h0C,  32'hAABBCCDD, 4'h5, OK, 32'h0,        2, 4'd3,  32'h11BB33DD, 0};
    vecs[3]  = '{1'b0, 32'h0C,  32'h0,        4'h0, OK, 32'h11BB33DD, 2, 4'd0,  32'h0,        0};
    vecs[4]  = '{1'b1, 32'h30,  32'h12345678, 4'hF, SE, 32'h0,        0, 4'd0,  32'h0,        0};
    vecs[5]  = '{1'b0, 32'h3C,  32'h0,        4'h0, SE, 32'h0,        1, 4'd0,  32'h0,        0};
    vecs[6]  = '{1'b1, 32'h04,  32'hCAFEF00D, 4'h0, OK, 32'h0,        0, 4'd0,  32'h0,        5};
    vecs[7]  = '{1'b0, 32'h04,  32'h0,        4'h0, OK, 32'h10000001, 2, 4'd0,  32'h0,        5};
    vecs[8]  = '{1'b1, 32'h42,  32'h0BADCAFE, 4'hF, OK, 32'h0,        1, 4'd0,  32'h0BADCAFE, 0};
    vecs[9]  = '{1'b0, 32'h101, 32'h0,        4'h0, OK, 32'h0BADCAFE, 2, 4'd0,  32'h0,        0};
    vecs[10] = '{1'b1, 32'h2C,  32'hEE000000, 4'h8, OK, 32'h0,        2, 4'd11, 32'hEE00000B, 0};
    vecs[11] = '{1'b0, 32'h2C,  32'h0,        4'h0, OK, 32'hEE00000B, 2, 4'd0,  32'h0,        0};

    bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b0; bus.ARADDR = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;

    // Preload the SRAM while reset is held.
    for (int i = 0; i < 16; i++) begin
      @(posedge CLK); #1;
      load_vld = 1'b1; load_idx = 4'(i);
      load_dat = (i == 3) ? 32'h11223344 : (i == 4) ? 32'h55AA55AA : 32'h10000000 + 32'(i);
    end
    @(posedge CLK); #1 load_vld = 1'b0;

    @(negedge CLK);
    check("rst_readys", 64'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 64'(0));
    check("rst_valids", 64'({bus.BVALID, bus.RVALID, WEN}), 64'(0));
    check("rst_resps", 64'({bus.BRESP, bus.RRESP}), 64'(0));
    check("rst_rdata", 64'(bus.RDATA), 64'(0));
    check("rst_sram", 64'({ADDR, W_DATA}), 64'(0));
    @(posedge CLK); #1 RST_N = 1'b1;

    // Simultaneous requests after reset: read first, then strict alternation.
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{1'b0, OK, 32'h55AA55AA});
      sb.push_back('{1'b1, OK, 32'h0});
      wq.push_back('{4'd4, 32'h55AA55AA});
    end
    bus.AWADDR = 32'h10; bus.WDATA = 32'h55AA55AA; bus.WSTRB = 4'hF; bus.ARADDR = 32'h10;
    bus.BREADY = 1'b1; bus.RREADY = 1'b1;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.ARVALID = 1'b1;
    ng = 0; t = 0;
    while (ng < 6 && t < 200) begin
      @(negedge CLK); t++;
      if (bus.ARREADY) begin grants[ng] = 1'b0; ng++; end
      else if (bus.AWREADY) begin grants[ng] = 1'b1; ng++; end
    end
    @(posedge CLK); #1;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    if (ng < 6) fail_to("arb_grants");
    for (int i = 0; i < ng; i++) check($sformatf("arb_grant%0d_is_wr", i), 64'(grants[i]), 64'(i % 2));
    t = 0;
    while ((sb.size() != 0 || wq.size() != 0) && t < 50) begin @(negedge CLK); t++; end
    check("arb_drained", 64'(sb.size() + wq.size()), 64'(0));
    @(posedge CLK); #1 bus.BREADY = 1'b0; bus.RREADY = 1'b0;

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) do_write(vecs[i]);
      else do_read(vecs[i]);
    end

    // Reset during the RMW read cycle aborts the write and its response.
    w0 = wen_cnt;
    @(posedge CLK); #1;
    bus.AWADDR = 32'h14; bus.WDATA = 32'hFFFFFFFF; bus.WSTRB = 4'h3;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    t = 0;
    do begin @(negedge CLK); t++; end while (!bus.AWREADY && t < 50);
    if (!bus.AWREADY) fail_to("rst_aw_handshake");
    @(posedge CLK); #1;
    RST_N = 1'b0; bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    @(negedge CLK);
    check("rst_mid_wen", 64'(WEN), 64'(0));
    check("rst_mid_bvalid", 64'(bus.BVALID), 64'(0));
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    t = 0;
    repeat (6) begin @(negedge CLK); if (WEN || bus.BVALID) t++; end
    check("rst_after_no_wen_b", 64'(t), 64'(0));
    check("rst_after_wen_cnt", 64'(wen_cnt - w0), 64'(0));
    check("rst_mem_untouched", 64'(mem[5]), 64'(32'h10000005));
    rv = '{1'b0, 32'h14, 32'h0, 4'h0, OK, 32'h10000005, 2, 4'd0, 32'h0, 0};
    do_read(rv);
    check("final_queues_empty", 64'(sb.size() + wq.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/axi4_lite_sram_bridge.md
Name: axi4_lite_sram_bridge

Overview:
- AXI4-Lite slave that converts bus transactions into single-port SRAM-style register-file accesses (ADDR, W_DATA, WEN, R_DATA).
- Sits between the interconnect and a generated register bank, and is the initiator for that bank's SRAM port.
- Serialises reads and writes onto the single port.
- Handles partial byte strobes by read-modify-write.
- Returns SLVERR for out-of-range addresses.

Parameters:
- AXI_ADDR_WIDTH, 32, AXI byte-address width.
- DATA_WIDTH, 32, data width for AXI and SRAM; must be 32 or 64.
- REG_ADDR_WIDTH, 4, SRAM word-address width.
- NUM_REGS, 16, implemented registers; must be <= 2**REG_ADDR_WIDTH.
- RD_LATENCY, 1, cycles from ADDR stable to R_DATA valid; must be >= 1.

Ports:
- CLK  in  1  clock
- RST_N  in  1  asynchronous active-low reset
- AWADDR  in  AXI_ADDR_WIDTH  write address
- AWVALID  in  1  write address valid
- AWREADY  out  1  write address ready
- WDATA  in  DATA_WIDTH  write data
- WSTRB  in  DATA_WIDTH/8  byte strobes
- WVALID  in  1  write data valid
- WREADY  out  1  write data ready
- BRESP  out  2  write response
- BVALID  out  1  write response valid
- BREADY  in  1  write response ready
- ARADDR  in  AXI_ADDR_WIDTH  read address
- ARVALID  in  1  read address valid
- ARREADY  out  1  read address ready
- RDATA  out  DATA_WIDTH  read data
- RRESP  out  2  read response
- RVALID  out  1  read data valid
- RREADY  in  1  read data ready
- ADDR  out  REG_ADDR_WIDTH  SRAM word address (registered)
- W_DATA  out  DATA_WIDTH  SRAM write data (registered)
- WEN  out  1  SRAM write enable, one-cycle pulse
- R_DATA  in  DATA_WIDTH  SRAM read data

Behaviour:
- Reset: RST_N asynchronous, active-low; clock CLK.
  - All outputs are 0 in reset: AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA, ADDR, W_DATA, WEN.
  - FSM goes to IDLE; the grant flag resets to "last=write".
  - Reset mid-transaction aborts it: no WEN is issued afterwards and the pending B/R response is dropped.
- Address decode:
  - Word index = AxADDR[OFF+REG_ADDR_WIDTH-1:OFF], with OFF = log2(DATA_WIDTH/8).
  - Low OFF bits are ignored. Upper address bits above the index are ignored.
  - Index >= NUM_REGS is an error: no SRAM write, response SLVERR (2'b10), RDATA = 0.
- Acceptance (IDLE only; one transaction in flight at a time):
  - A write is pending when AWVALID and WVALID are both high. A read is pending when ARVALID is high.
  - If both are pending, grant the direction opposite to the last served; otherwise grant the single pending one.
  - Write grant: AWREADY and WREADY pulse high together for 1 cycle; AWADDR, WDATA and WSTRB are captured.
  - Read grant: ARREADY pulses high for 1 cycle; ARADDR is captured.
  - READY is never asserted outside IDLE.
- States: IDLE, WR_RD, WR_EXEC, WR_RESP, RD_WAIT, RD_RESP.
- Write, WSTRB all ones, in range: IDLE -> WR_EXEC.
  - In WR_EXEC, ADDR = index, W_DATA = WDATA, WEN = 1 for exactly one cycle.
  - Then WR_RESP: BVALID = 1, BRESP = OKAY. WEN is first visible 1 cycle after the handshake.
- Write, partial WSTRB (nonzero, not all ones), in range: IDLE -> WR_RD.
  - In WR_RD, ADDR = index and WEN = 0 for RD_LATENCY cycles; R_DATA is sampled in the last of these cycles.
  - Then WR_EXEC writes a merged word: each byte = WDATA byte where its strobe = 1, else R_DATA byte.
  - Then WR_RESP.
- Write with WSTRB = 0, or an error write: IDLE -> WR_RESP directly, no SRAM access. BRESP is OKAY for WSTRB = 0 and SLVERR for an error.
- WR_RESP: BVALID and BRESP are held until BREADY; on the handshake cycle go to IDLE with BVALID = 0 the next cycle.
- Read, in range: IDLE -> RD_WAIT.
  - ADDR = index for RD_LATENCY cycles; R_DATA is captured into RDATA in the last cycle.
  - Then RD_RESP: RVALID = 1, RRESP = OKAY.
  - Latency from the AR handshake to RVALID is RD_LATENCY + 1 cycles.
- Read error: IDLE -> RD_RESP directly, RDATA = 0, RRESP = SLVERR.
- RD_RESP: RDATA, RRESP and RVALID are held stable until RREADY, then go to IDLE.
- The grant flag updates on each granted handshake.
- ADDR and W_DATA hold their last values when idle; WEN is 0 in every state except WR_EXEC.
- Back-to-back: the next grant can occur in the IDLE cycle immediately following a response handshake.

Test Plan:
- Full write then read: AW=0x08 WDATA=0xDEADBEEF WSTRB=0xF, then AR=0x08 -> WEN pulse with ADDR=2, W_DATA=0xDEADBEEF; BRESP=OKAY; RDATA=0xDEADBEEF, RVALID 2 cycles after ARREADY (RD_LATENCY=1).
- Partial RMW: reg3=0x11223344, write AW=0x0C WDATA=0xAABBCCDD WSTRB=0b0101 -> one read cycle then WEN with W_DATA=0x11BB33DD; exactly one WEN pulse.
- Out of range with NUM_REGS=12: write AW=0x30 and read AR=0x3C -> no WEN; BRESP=2'b10; RRESP=2'b10 with RDATA=0.
- Simultaneous AW/W/AR in IDLE after reset -> read granted first and write granted next; with continuous requests, grants strictly alternate R, W, R, W.
- Backpressure: hold BREADY/RREADY low for 5 cycles -> BVALID/RVALID and RDATA/RESP stable, no READY asserted; WSTRB=0 write -> OKAY with no WEN.
- Reset asserted during WR_RD, then released -> WEN never pulses, BVALID stays 0, FSM in IDLE accepting a new request.
